// File: rtl/mux_16x1_rr.sv
// 16-to-1 round-robin multiplexer with a registered valid/ready output stage.
// Each word is tagged with its source channel index on sel_out.
module mux_16x1_rr #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*DATA_W-1:0]  data_in,
  input  logic [15:0]           valid_in,
  output logic [15:0]           ready_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [3:0]            sel_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        lastGrant_q, lastGrant_d;

  logic              loadOk;
  logic              anyValid;
  logic              load;
  logic [3:0]        winner;
  logic [3:0]        scanIdx;

  // Scan starts one past the previous winner so every channel gets its turn.
  always_comb begin
    winner   = '0;
    anyValid = 1'b0;
    scanIdx  = '0;
    for (int k = 1; k <= 16; k++) begin
      scanIdx = lastGrant_q + 4'(k);
      if (!anyValid && valid_in[scanIdx]) begin
        winner   = scanIdx;
        anyValid = 1'b1;
      end
    end
  end

  assign loadOk    = !valid_q || ready_in;
  assign load      = !rst && loadOk && anyValid;
  assign ready_out = load ? (16'd1 << winner) : 16'd0;

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    sel_d       = sel_q;
    lastGrant_d = lastGrant_q;
    if (load) begin
      valid_d     = 1'b1;
      data_d      = data_in[winner*DATA_W +: DATA_W];
      sel_d       = winner;
      lastGrant_d = winner;
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  // Pointer resets to 15 so the first scan after reset begins at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      sel_q       <= '0;
      lastGrant_q <= 4'd15;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sel_out   = sel_q;

endmodule
